// File: rtl/regfile_sb_if.sv
// Register file bus: write, reserve, read, debug and status signals.
// Zero latency: the bundle only carries wires.
// No backpressure: every strobe is accepted on the edge it is presented.
interface regfile_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic [ADDR_W-1:0] rd2_addr;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              rd1_pend;
    logic              rd2_pend;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [ADDR_W:0]   pend_cnt;
    logic              rsv_err;

    // Pipeline side: drives strobes and addresses, observes read results.
    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd1_addr, rd2_addr, dbg_addr,
        input  rd1_data, rd2_data, rd1_pend, rd2_pend,
        input  dbg_data, pend_cnt, rsv_err
    );

    // Register file side.
    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd1_addr, rd2_addr, dbg_addr,
        output rd1_data, rd2_data, rd1_pend, rd2_pend,
        output dbg_data, pend_cnt, rsv_err
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-entry pending scoreboard; optional write forwarding (RF_BYPASS_EN).
// Reads are combinational (0 cycles); write/reserve take effect at the next rising edge.
// No backpressure: the scoreboard only reports pending state, the issue stage decides to stall.
module regfile_sb #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              err;
    logic              err_set;

    // Next pending vector: a write releases its entry, a reserve claims one.
    // Reserve is applied last so a same-cycle release and re-reserve leaves it pending.
    always_comb begin
        pend_nxt = pend;
        if (bus.wr_en) begin
            pend_nxt[bus.wr_addr] = 1'b0;
        end
        if (bus.rsv_en) begin
            pend_nxt[bus.rsv_addr] = 1'b1;
        end
    end

    // Double reservation: only an error when the stored pending bit is not being released now.
    always_comb begin
        err_set = bus.rsv_en && pend[bus.rsv_addr]
                  && !(bus.wr_en && (bus.wr_addr == bus.rsv_addr));
    end

    // Population count of the next pending vector, registered alongside it.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
        end
    end

    // Storage and scoreboard state; reset clears every entry and drops any strobe of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (bus.wr_en) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

`ifdef RF_BYPASS_EN
    logic fwd1;
    logic fwd2;
    logic fwd_pend;

    // Forward the writeback value; the result stays pending only if it is re-reserved this cycle.
    always_comb begin
        fwd1     = bus.wr_en && (bus.rd1_addr == bus.wr_addr);
        fwd2     = bus.wr_en && (bus.rd2_addr == bus.wr_addr);
        fwd_pend = bus.rsv_en && (bus.rsv_addr == bus.wr_addr);
        bus.rd1_data = fwd1 ? bus.wr_data : mem[bus.rd1_addr];
        bus.rd2_data = fwd2 ? bus.wr_data : mem[bus.rd2_addr];
        bus.rd1_pend = fwd1 ? fwd_pend : pend[bus.rd1_addr];
        bus.rd2_pend = fwd2 ? fwd_pend : pend[bus.rd2_addr];
    end
`else
    // Reads return stored state only; a new write shows up the cycle after it lands.
    always_comb begin
        bus.rd1_data = mem[bus.rd1_addr];
        bus.rd2_data = mem[bus.rd2_addr];
        bus.rd1_pend = pend[bus.rd1_addr];
        bus.rd2_pend = pend[bus.rd2_addr];
    end
`endif

    // Debug port and status always reflect stored state.
    always_comb begin
        bus.dbg_data = mem[bus.dbg_addr];
        bus.pend_cnt = cnt;
        bus.rsv_err  = err;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb at 8x8 and 16x16, with or without RF_BYPASS_EN.
// Inputs driven on the falling edge, outputs compared 1 ns later, state updates on the rising edge.
// Vectors list the combinational outputs expected before the edge that consumes them.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(8),  .ADDR_W(3)) ifa ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) ifb ();

    regfile_sb #(.DATA_W(8),  .DEPTH(8),  .ADDR_W(3)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    regfile_sb #(.DATA_W(16), .DEPTH(16), .ADDR_W(4)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    typedef struct {
        logic       rst;
        logic       wen;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       ren;
        logic [2:0] ra;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [2:0] ad;
        logic [7:0] e1;
        logic       p1;
        logic [7:0] e2;
        logic       p2;
        logic [7:0] ed;
        logic [3:0] ecnt;
        logic       eerr;
    } vec_t;

    vec_t tbl[14];

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv_a(input logic r, input logic wen, input logic [2:0] wa, input logic [7:0] wd,
                         input logic ren, input logic [2:0] ra,
                         input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] ad);
        @(negedge clk);
        rst_a        = r;
        ifa.wr_en    = wen;
        ifa.wr_addr  = wa;
        ifa.wr_data  = wd;
        ifa.rsv_en   = ren;
        ifa.rsv_addr = ra;
        ifa.rd1_addr = a1;
        ifa.rd2_addr = a2;
        ifa.dbg_addr = ad;
        #1;
    endtask

    task automatic drv_b(input logic r, input logic wen, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] ad);
        @(negedge clk);
        rst_b        = r;
        ifb.wr_en    = wen;
        ifb.wr_addr  = wa;
        ifb.wr_data  = wd;
        ifb.rsv_en   = 1'b0;
        ifb.rsv_addr = '0;
        ifb.rd1_addr = a1;
        ifb.rd2_addr = a2;
        ifb.dbg_addr = ad;
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;
        logic       exp_p;

        //          rst  wen  wa  wd     ren  ra  a1  a2  ad   e1     p1   e2     p2   ed     cnt  err
        tbl[0]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd2,3'd3,3'd2,3'd3,8'hA5,1'b0,8'h00,1'b0,8'hA5,4'd0,1'b0};
        tbl[1]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd5,3'd2,3'd5,3'd0,8'h00,1'b1,8'h00,1'b0,8'h00,4'd1,1'b0};
        tbl[2]  = '{1'b0,1'b1,3'd2,8'h3C,1'b0,3'd0,3'd5,3'd5,3'd2,8'h00,1'b1,8'h00,1'b1,8'h00,4'd2,1'b0};
        tbl[3]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd2,3'd5,3'd2,8'h3C,1'b0,8'h00,1'b1,8'h3C,4'd1,1'b0};
        tbl[4]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd5,3'd2,3'd3,3'd5,8'h3C,1'b0,8'hA5,1'b0,8'h00,4'd1,1'b0};
        tbl[5]  = '{1'b0,1'b1,3'd5,8'h77,1'b0,3'd0,3'd0,3'd1,3'd5,8'h00,1'b0,8'h00,1'b0,8'h00,4'd1,1'b1};
        tbl[6]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd4,3'd5,3'd4,3'd5,8'h77,1'b0,8'h00,1'b0,8'h77,4'd0,1'b1};
        tbl[7]  = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd4,3'd5,3'd4,8'h00,1'b1,8'h77,1'b0,8'h00,4'd1,1'b1};
        tbl[8]  = '{1'b1,1'b1,3'd6,8'h99,1'b1,3'd6,3'd5,3'd4,3'd5,8'h77,1'b0,8'h00,1'b1,8'h77,4'd1,1'b1};
        tbl[9]  = '{1'b0,1'b0,3'd0,8'h00,1'b1,3'd4,3'd6,3'd5,3'd6,8'h00,1'b0,8'h00,1'b0,8'h00,4'd0,1'b0};
        tbl[10] = '{1'b0,1'b1,3'd4,8'h5A,1'b1,3'd4,3'd3,3'd3,3'd4,8'h00,1'b0,8'h00,1'b0,8'h00,4'd1,1'b0};
        tbl[11] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd4,3'd4,3'd4,8'h5A,1'b1,8'h5A,1'b1,8'h5A,4'd1,1'b0};
        tbl[12] = '{1'b0,1'b1,3'd1,8'h12,1'b0,3'd0,3'd4,3'd0,3'd1,8'h5A,1'b1,8'h00,1'b0,8'h00,4'd1,1'b0};
        tbl[13] = '{1'b0,1'b0,3'd0,8'h00,1'b0,3'd0,3'd1,3'd4,3'd1,8'h12,1'b0,8'h5A,1'b1,8'h12,4'd1,1'b0};

        drv_a(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        drv_b(1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 4'd0);
        drv_a(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        drv_b(1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 4'd0);
        cmp("reset rd1", {8'h00, ifa.rd1_data}, 16'h0000);
        cmp("reset pend_cnt", {12'h000, ifa.pend_cnt}, 16'h0000);
        cmp("reset rsv_err", {15'h0, ifa.rsv_err}, 16'h0000);

        // Preload r0..r7 = 0x11..0x88, then reset must clear all of them.
        for (int i = 0; i < 8; i++) begin
            drv_a(1'b0, 1'b1, 3'(i), 8'(8'h11 * (i + 1)), 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        end
        drv_a(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd0, 3'd0, 3'd7);
        cmp("preload r7", {8'h00, ifa.dbg_data}, 16'h0088);
        drv_a(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            drv_a(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'(i), 3'(i), 3'(i));
            cmp($sformatf("rst clear dbg r%0d", i), {8'h00, ifa.dbg_data}, 16'h0000);
        end
        cmp("rst clear pend_cnt", {12'h000, ifa.pend_cnt}, 16'h0000);
        cmp("rst clear rd1_pend", {15'h0, ifa.rd1_pend}, 16'h0000);

        // Write r3 = A5 while reading r3 in the same cycle.
        drv_a(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd3, 3'd3, 3'd3);
`ifdef RF_BYPASS_EN
        exp_d = 8'hA5;
`else
        exp_d = 8'h00;
`endif
        cmp("same-cycle rd1 r3", {8'h00, ifa.rd1_data}, {8'h00, exp_d});
        cmp("same-cycle dbg r3", {8'h00, ifa.dbg_data}, 16'h0000);

        for (int i = 0; i < 14; i++) begin
            drv_a(tbl[i].rst, tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].ren, tbl[i].ra,
                  tbl[i].a1, tbl[i].a2, tbl[i].ad);
            cmp($sformatf("t%0d rd1_data", i), {8'h00, ifa.rd1_data}, {8'h00, tbl[i].e1});
            cmp($sformatf("t%0d rd1_pend", i), {15'h0, ifa.rd1_pend}, {15'h0, tbl[i].p1});
            cmp($sformatf("t%0d rd2_data", i), {8'h00, ifa.rd2_data}, {8'h00, tbl[i].e2});
            cmp($sformatf("t%0d rd2_pend", i), {15'h0, ifa.rd2_pend}, {15'h0, tbl[i].p2});
            cmp($sformatf("t%0d dbg_data", i), {8'h00, ifa.dbg_data}, {8'h00, tbl[i].ed});
            cmp($sformatf("t%0d pend_cnt", i), {12'h000, ifa.pend_cnt}, {12'h000, tbl[i].ecnt});
            cmp($sformatf("t%0d rsv_err", i), {15'h0, ifa.rsv_err}, {15'h0, tbl[i].eerr});
        end

        // Forwarding corner: write and reserve r3 together; pending forwarded only with the reserve.
        drv_a(1'b0, 1'b1, 3'd3, 8'hC3, 1'b1, 3'd3, 3'd3, 3'd7, 3'd3);
`ifdef RF_BYPASS_EN
        exp_d = 8'hC3; exp_p = 1'b1;
`else
        exp_d = 8'h00; exp_p = 1'b0;
`endif
        cmp("fwd rd1_data wr+rsv", {8'h00, ifa.rd1_data}, {8'h00, exp_d});
        cmp("fwd rd1_pend wr+rsv", {15'h0, ifa.rd1_pend}, {15'h0, exp_p});
        cmp("fwd dbg unaffected", {8'h00, ifa.dbg_data}, 16'h0000);
        // Release pending r4 with a write; no reserve so the forwarded copy is not pending.
        drv_a(1'b0, 1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 3'd3, 3'd4, 3'd4);
        cmp("after wr+rsv rd1_data", {8'h00, ifa.rd1_data}, 16'h00C3);
        cmp("after wr+rsv rd1_pend", {15'h0, ifa.rd1_pend}, 16'h0001);
        cmp("after wr+rsv pend_cnt", {12'h000, ifa.pend_cnt}, 16'h0002);
`ifdef RF_BYPASS_EN
        exp_d = 8'h44; exp_p = 1'b0;
`else
        exp_d = 8'h5A; exp_p = 1'b1;
`endif
        cmp("fwd rd2_data wr", {8'h00, ifa.rd2_data}, {8'h00, exp_d});
        cmp("fwd rd2_pend wr", {15'h0, ifa.rd2_pend}, {15'h0, exp_p});
        drv_a(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd4, 3'd4);
        cmp("r4 release rd1_data", {8'h00, ifa.rd1_data}, 16'h0044);
        cmp("r4 release rd1_pend", {15'h0, ifa.rd1_pend}, 16'h0000);
        cmp("r4 release pend_cnt", {12'h000, ifa.pend_cnt}, 16'h0001);

        // Wide configuration: both read ports at the extreme addresses, then reset mid-write.
        drv_b(1'b0, 1'b1, 4'd15, 16'hBEEF, 4'd0, 4'd0, 4'd0);
        drv_b(1'b0, 1'b1, 4'd0, 16'h0001, 4'd0, 4'd0, 4'd0);
        drv_b(1'b0, 1'b1, 4'd9, 16'hABCD, 4'd15, 4'd0, 4'd9);
        cmp("wide rd1 r15", ifb.rd1_data, 16'hBEEF);
        cmp("wide rd2 r0", ifb.rd2_data, 16'h0001);
        drv_b(1'b0, 1'b0, 4'd0, 16'h0000, 4'd9, 4'd15, 4'd9);
        cmp("wide r9 written", ifb.rd1_data, 16'hABCD);
        drv_b(1'b1, 1'b1, 4'd9, 16'h1234, 4'd9, 4'd15, 4'd9);
        drv_b(1'b0, 1'b0, 4'd0, 16'h0000, 4'd9, 4'd15, 4'd9);
        cmp("wide rst r9 rd1", ifb.rd1_data, 16'h0000);
        cmp("wide rst r9 dbg", ifb.dbg_data, 16'h0000);
        cmp("wide rst r15", ifb.rd2_data, 16'h0000);
        cmp("wide pend_cnt", {11'h000, ifb.pend_cnt}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-entry pending scoreboard for the pipelined processor datapath. Provides two combinational read ports and one synchronous write port, plus a dedicated debug read port. Tracks which destination registers have an in-flight write, so decode can stall on RAW hazards. Optional write-to-read forwarding is compiled in by macro.

## Interface
- DATA_W, 8, register width in bits
- DEPTH, 8, number of registers (power of two, ≥2)
- ADDR_W, 3, address width; must equal log2(DEPTH)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe (writeback stage)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve strobe: mark rsv_addr pending (issue stage)
- rsv_addr  in  ADDR_W  register being reserved
- rd1_addr, rd2_addr  in  ADDR_W  read addresses
- rd1_data, rd2_data  out  DATA_W  read data (combinational)
- rd1_pend, rd2_pend  out  1  addressed register has an outstanding write
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (never forwarded)
- pend_cnt  out  ADDR_W+1  number of pending registers
- rsv_err  out  1  sticky: reserve hit an already-pending register

## Operation
- State: DEPTH×DATA_W data array, DEPTH-bit pend vector, sticky rsv_err.
- Reset (rst=1 at edge): **every** entry 0..DEPTH-1 cleared to 0, pend all 0, rsv_err 0. rst overrides wr_en/rsv_en in that cycle.
- Write (wr_en=1): mem[wr_addr] ← wr_data; pend[wr_addr] ← 0.
- Reserve (rsv_en=1): pend[rsv_addr] ← 1. If pend[rsv_addr] already 1 (stored value, before this edge) → rsv_err ← 1; pend stays 1.
- Simultaneous write and reserve to same address: data written, pend ends 1 (reserve wins; new producer issued). rsv_err set only if the stored pend was already 1 and not being cleared by this write; a release and re-reserve in the same cycle is legal.
- Write to a non-pending register: legal, data updated, pend unchanged at 0.
- pend_cnt = popcount(pend), registered value consistent with pend after each edge; range 0..DEPTH.
- Reads: rdN_data = mem[rdN_addr]; rdN_pend = pend[rdN_addr] (modified by bypass, see Configuration). Both read ports may address the same register.
- dbg_data = mem[dbg_addr] always, no bypass, no side effects.
- Out-of-range addresses cannot occur (ADDR_W = log2 DEPTH).

## Timing
- Read ports: zero latency, combinational from address and stored state.
- Write/reserve: take effect at the rising edge; visible on read ports from the following cycle (without bypass).
- Reset values seen the cycle after rst edge: all rdN_data/dbg_data 0, rdN_pend 0, pend_cnt 0, rsv_err 0.
- Reset asserted mid-stream discards any wr_en/rsv_en in that cycle; no partial clear.
- rsv_err cleared only by rst.

## Configuration
- RF_BYPASS_EN defined: when wr_en=1 and rdN_addr==wr_addr, rdN_data = wr_data and rdN_pend = 0 in the same cycle (combinational forward). rdN_pend is 1 only if, additionally, rsv_en=1 with rsv_addr==wr_addr; reservations are not forwarded otherwise. dbg port unaffected.
- RF_BYPASS_EN undefined: reads return stored state only; new write visible next cycle.

## Test plan
- Reset with DEPTH=8: preload r0..r7 = 0x11..0x88, pulse rst -> all eight read 0x00 via dbg port, including r7; pend_cnt=0.
- Write r3=0xA5 -> rd1_addr=3 reads 0xA5 next cycle; same cycle reads old value without bypass, 0xA5 with RF_BYPASS_EN.
- Reserve r2, r5 on consecutive cycles -> pend_cnt 1 then 2, rd1_pend=1 for addr 2; write r2=0x3C -> rd1_pend=0, pend_cnt=1.
- Reserve r5 again while pending -> rsv_err=1, stays 1 after writing r5; clears only on rst.
- Same cycle wr_en/rsv_en both to r4 (r4 pending) -> mem[4]=wr_data, pend[4]=1, rsv_err stays 0, pend_cnt unchanged.
- DATA_W=16, DEPTH=16, ADDR_W=4: write r15=0xBEEF, r0=0x0001 -> rd1/rd2 return both simultaneously; rst mid-write of r9 -> r9 reads 0.
